xm_wb_mem: RTL and testbench

- Wishbone-classic responder: single-port word RAM with byte-lane writes and a programmable wait-state count.
- Sits on the CPU data/instruction bus as the far end of the CPU's initiator interface (stb/cyc/we/sel/adr/dat out; ack/dat in).
- Provides program/data storage for the multi-cycle core and lets the bench exercise CPU stall paths via wait states.

---
 rtl/xm_bus_pkg.sv | 26 ++
 rtl/xm_ram_bytelane.sv | 32 +++
 rtl/xm_wb_mem.sv | 154 +++++++++++++++
 tb/tb_xm_wb_mem.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/xm_bus_pkg.sv
// Shared bus definitions for the Wishbone word RAM: FSM states, byte-lane
// select encodings, the default word width and the request error check.
package xm_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } busStateT;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_LO   = 2'b01;
    localparam logic [1:0] SEL_HI   = 2'b10;
    localparam logic [1:0] SEL_WORD = 2'b11;

    localparam int WORD_DEFAULT = 16;

    // Out-of-range address, empty lane select, or a misaligned full-word access.
    function automatic logic reqError(input logic [15:0] adr, input logic [1:0] sel,
                                      input int unsigned depthLog2);
        logic [15:0] highBits;
        highBits = adr >> (depthLog2 + 1);
        return (highBits != 16'h0000) || (sel == SEL_NONE) || ((sel == SEL_WORD) && adr[0]);
    endfunction

endpackage

// File: rtl/xm_ram_bytelane.sv
// One 8-bit synchronous RAM lane with a registered read port; the top uses
// two of these so byte-lane masking stays out of the bus FSM.
module xm_ram_bytelane #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  wrEn,
    input  logic                  rdEn,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [7:0]            wrData,
    output logic [7:0]            rdData
);

    logic [7:0] mem [2**DEPTH_LOG2];

    // NOTE: the storage array has no reset so it maps onto block RAM; only the read register is cleared.
    always_ff @(posedge clk_i) begin
        if (wrEn) begin
            mem[addr] <= wrData;
        end
    end

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            rdData <= 8'h00;
        end else if (rdEn) begin
            rdData <= mem[addr];
        end
    end

endmodule

// File: rtl/xm_wb_mem.sv
// Wishbone-classic word RAM responder with byte-lane writes and WAIT wait states.
// Define XM_WB_MEM_ERR_EN to add err_o and reject malformed requests.
module xm_wb_mem
    import xm_bus_pkg::*;
#(
    parameter int WORD       = WORD_DEFAULT,
    parameter int DEPTH_LOG2 = 10,
    parameter int WAIT       = 1
) (
`ifdef XM_WB_MEM_ERR_EN
    output logic            err_o,
`endif
    input  logic            clk_i,
    input  logic            arst_i,
    input  logic            cyc_i,
    input  logic            stb_i,
    input  logic            we_i,
    input  logic [1:0]      sel_i,
    input  logic [WORD-1:0] adr_i,
    input  logic [WORD-1:0] dat_i,
    output logic            ack_o,
    output logic [WORD-1:0] dat_o
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT);

    busStateT state, nextState;
    logic [3:0] waitCnt;

    logic [DEPTH_LOG2-1:0] idxQ;
    logic                  weQ;
    logic [1:0]            selQ;
    logic [WORD-1:0]       datQ;

    logic [DEPTH_LOG2-1:0] curIdx;
    logic                  curWe;
    logic [1:0]            curSel;
    logic [WORD-1:0]       curDat;
    logic                  curErr;

    logic newReq, enterAck, wrEn, rdEn;

    assign newReq = (state == ST_IDLE) && cyc_i && stb_i;

    // With WAIT = 0 the ACK edge is also the request edge, so use the live bus fields then.
    always_comb begin
        if (state == ST_IDLE) begin
            curIdx = adr_i[DEPTH_LOG2:1];
            curWe  = we_i;
            curSel = sel_i;
            curDat = dat_i;
        end else begin
            curIdx = idxQ;
            curWe  = weQ;
            curSel = selQ;
            curDat = datQ;
        end
    end

`ifdef XM_WB_MEM_ERR_EN
    logic errQ;
    assign curErr = (state == ST_IDLE) ? reqError(adr_i, sel_i, DEPTH_LOG2) : errQ;
`else
    logic unusedAdr;
    assign unusedAdr = ^{adr_i[0], adr_i[WORD-1:DEPTH_LOG2+1]};
    assign curErr    = 1'b0;
`endif

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: begin
                if (cyc_i && stb_i) begin
                    nextState = (WAIT == 0) ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!cyc_i) begin
                    nextState = ST_IDLE;
                end else if (waitCnt <= 4'd1) begin
                    nextState = ST_ACK;
                end
            end
            ST_ACK:  nextState = ST_IDLE;
            default: nextState = ST_IDLE;
        endcase
    end

    assign enterAck = (nextState == ST_ACK) && !arst_i;
    assign wrEn     = enterAck && curWe && !curErr;
    assign rdEn     = enterAck && !curWe && !curErr;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state   <= ST_IDLE;
            waitCnt <= 4'd0;
            ack_o   <= 1'b0;
        end else begin
            state <= nextState;
            ack_o <= enterAck && !curErr;
            if (newReq) begin
                waitCnt <= WAIT_LOAD;
            end else if ((state == ST_WAIT) && (waitCnt != 4'd0)) begin
                waitCnt <= waitCnt - 4'd1;
            end
        end
    end

    // Request payload is only consumed outside IDLE, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (newReq) begin
            idxQ <= adr_i[DEPTH_LOG2:1];
            weQ  <= we_i;
            selQ <= sel_i;
            datQ <= dat_i;
        end
    end

`ifdef XM_WB_MEM_ERR_EN
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            err_o <= 1'b0;
            errQ  <= 1'b0;
        end else begin
            err_o <= enterAck && curErr;
            if (newReq) begin
                errQ <= curErr;
            end
        end
    end
`endif

    xm_ram_bytelane #(.DEPTH_LOG2(DEPTH_LOG2)) laneLo (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .wrEn   (wrEn && curSel[0]),
        .rdEn   (rdEn),
        .addr   (curIdx),
        .wrData (curDat[7:0]),
        .rdData (dat_o[7:0])
    );

    xm_ram_bytelane #(.DEPTH_LOG2(DEPTH_LOG2)) laneHi (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .wrEn   (wrEn && curSel[1]),
        .rdEn   (rdEn),
        .addr   (curIdx),
        .wrData (curDat[15:8]),
        .rdData (dat_o[15:8])
    );

endmodule

// File: tb/tb_xm_wb_mem.sv
// Self-checking bench for xm_wb_mem: three instances (WAIT = 0, 1, 3) driven by
// directed and random transfers against a word-array reference model.
module tb_xm_wb_mem;

    logic        clk = 1'b0;
    logic        arst;
    logic [2:0]  cycV;
    logic        stb, we;
    logic [1:0]  sel;
    logic [15:0] adr, datIn;
    logic [2:0]  ackV, errV;
    logic [15:0] datV [3];

    int nCompared   = 0;
    int nMismatched = 0;

    logic [15:0] model   [3][1024];
    bit          known   [3][1024];
    logic [15:0] lastDat [3];
    int          waitOf  [3] = '{0, 1, 3};

    always #5 clk = ~clk;

`ifndef XM_WB_MEM_ERR_EN
    assign errV = 3'b000;
`endif

    xm_wb_mem #(.WAIT(0)) u0 (
`ifdef XM_WB_MEM_ERR_EN
        .err_o(errV[0]),
`endif
        .clk_i(clk), .arst_i(arst), .cyc_i(cycV[0]), .stb_i(stb), .we_i(we),
        .sel_i(sel), .adr_i(adr), .dat_i(datIn), .ack_o(ackV[0]), .dat_o(datV[0]));

    xm_wb_mem #(.WAIT(1)) u1 (
`ifdef XM_WB_MEM_ERR_EN
        .err_o(errV[1]),
`endif
        .clk_i(clk), .arst_i(arst), .cyc_i(cycV[1]), .stb_i(stb), .we_i(we),
        .sel_i(sel), .adr_i(adr), .dat_i(datIn), .ack_o(ackV[1]), .dat_o(datV[1]));

    xm_wb_mem #(.WAIT(3)) u3 (
`ifdef XM_WB_MEM_ERR_EN
        .err_o(errV[2]),
`endif
        .clk_i(clk), .arst_i(arst), .cyc_i(cycV[2]), .stb_i(stb), .we_i(we),
        .sel_i(sel), .adr_i(adr), .dat_i(datIn), .ack_o(ackV[2]), .dat_o(datV[2]));

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int idxOf(input logic [15:0] a);
        return (int'(a) / 2) % 1024;
    endfunction

    function automatic logic predErr(input logic [15:0] a, input logic [1:0] s);
`ifdef XM_WB_MEM_ERR_EN
        return (a >= 16'h0800) || (s == 2'b00) || ((s == 2'b11) && a[0]);
`else
        return 1'b0;
`endif
    endfunction

    // One complete transfer on instance k, checked against the model; rd returns dat_o at response time.
    task automatic xfer(input int k, input logic w, input logic [1:0] s, input logic [15:0] a,
                        input logic [15:0] d, output logic [15:0] rd);
        int   lat;
        int   ix;
        logic expErr;
        expErr = predErr(a, s);
        ix     = idxOf(a);
        @(negedge clk);
        cycV = 3'b000; cycV[k] = 1'b1;
        stb = 1'b1; we = w; sel = s; adr = a; datIn = d;
        lat = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ackV[k] || errV[k]) lat = c;
        end
        check($sformatf("latency_u%0d", k), 16'(lat), 16'(waitOf[k] + 1));
        check($sformatf("resp_u%0d", k), {14'b0, ackV[k], errV[k]}, expErr ? 16'd1 : 16'd2);
        rd = datV[k];
        if (expErr) begin
            check($sformatf("dat_hold_u%0d", k), datV[k], lastDat[k]);
        end else if (!w) begin
            if (known[k][ix]) begin
                check($sformatf("rdata_u%0d_w%0d", k, ix), datV[k], model[k][ix]);
                lastDat[k] = model[k][ix];
            end
        end else begin
            if (s[0]) model[k][ix][7:0]  = d[7:0];
            if (s[1]) model[k][ix][15:8] = d[15:8];
            if (s == 2'b11) known[k][ix] = 1'b1;
        end
        cycV = 3'b000; stb = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check($sformatf("ack_pulse_u%0d", k), {15'b0, ackV[k]}, 16'd0);
    endtask

    initial begin
        logic [15:0] rd;
        arst = 1'b1; cycV = 3'b000; stb = 1'b0; we = 1'b0;
        sel = 2'b00; adr = 16'h0000; datIn = 16'h0000;
        lastDat = '{16'h0, 16'h0, 16'h0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        arst = 1'b0;

        // Idle after reset: no ack, dat_o cleared.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("reset_ack", {15'b0, ackV[1]}, 16'd0);
            check("reset_dat", datV[1], 16'h0000);
        end

        // Word write, read back, then per-lane byte writes (WAIT = 1).
        xfer(1, 1'b1, 2'b11, 16'h0010, 16'hBEEF, rd);
        xfer(1, 1'b0, 2'b11, 16'h0010, 16'h0000, rd);
        check("word_rd", rd, 16'hBEEF);
        xfer(1, 1'b1, 2'b01, 16'h0010, 16'h0012, rd);
        xfer(1, 1'b0, 2'b11, 16'h0010, 16'h0000, rd);
        check("lo_byte_rd", rd, 16'hBE12);
        xfer(1, 1'b1, 2'b10, 16'h0010, 16'h3400, rd);
        xfer(1, 1'b0, 2'b11, 16'h0010, 16'h0000, rd);
        check("hi_byte_rd", rd, 16'h3412);

        // Empty lane select: no write (and an error response when checking is enabled).
        xfer(1, 1'b1, 2'b00, 16'h0010, 16'hFFFF, rd);
        xfer(1, 1'b0, 2'b11, 16'h0010, 16'h0000, rd);
        check("sel00_rd", rd, 16'h3412);

        // WAIT = 0 with the strobe held through ACK: acks on alternate cycles only.
        xfer(0, 1'b1, 2'b11, 16'h0020, 16'hC0DE, rd);
        @(negedge clk);
        cycV = 3'b001; stb = 1'b1; we = 1'b0; sel = 2'b11; adr = 16'h0020;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("b2b_ack_c%0d", c), {15'b0, ackV[0]}, (c % 2 == 1) ? 16'd1 : 16'd0);
            if (c % 2 == 1) check($sformatf("b2b_dat_c%0d", c), datV[0], 16'hC0DE);
        end
        cycV = 3'b000; stb = 1'b0;
        lastDat[0] = 16'hC0DE;

        // cyc_i dropped mid-wait (WAIT = 3): aborted write, no ack.
        xfer(2, 1'b1, 2'b11, 16'h0040, 16'h1111, rd);
        @(negedge clk);
        cycV = 3'b100; stb = 1'b1; we = 1'b1; sel = 2'b11; adr = 16'h0040; datIn = 16'h5555;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("abort_ack_wait", {15'b0, ackV[2]}, 16'd0);
        end
        cycV = 3'b000; stb = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("abort_ack_after", {15'b0, ackV[2]}, 16'd0);
        end
        xfer(2, 1'b0, 2'b11, 16'h0040, 16'h0000, rd);
        check("abort_keep", rd, 16'h1111);

        // Reset during WAIT: transfer abandoned, RAM keeps its contents, dat_o cleared.
        @(negedge clk);
        cycV = 3'b100; stb = 1'b1; we = 1'b1; sel = 2'b11; adr = 16'h0040; datIn = 16'h7777;
        @(posedge clk);
        @(negedge clk);
        arst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        arst = 1'b0; cycV = 3'b000; stb = 1'b0;
        lastDat = '{16'h0, 16'h0, 16'h0};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("rst_wait_ack", {15'b0, ackV[2]}, 16'd0);
        end
        check("rst_wait_dat", datV[2], 16'h0000);
        xfer(2, 1'b0, 2'b11, 16'h0040, 16'h0000, rd);
        check("rst_wait_keep", rd, 16'h1111);

        // Out-of-range address: aliases without checking, rejected with checking.
        xfer(1, 1'b1, 2'b11, 16'h0000, 16'h0F0F, rd);
        xfer(1, 1'b1, 2'b11, 16'h0800, 16'hA5A5, rd);
        xfer(1, 1'b0, 2'b11, 16'h0000, 16'h0000, rd);
`ifdef XM_WB_MEM_ERR_EN
        check("oob_no_write", rd, 16'h0F0F);
`else
        check("oob_alias", rd, 16'hA5A5);
`endif
        // Odd address with a full-word select.
        xfer(1, 1'b0, 2'b11, 16'h0011, 16'h0000, rd);
`ifdef XM_WB_MEM_ERR_EN
        check("misaligned_hold", rd, lastDat[1]);
`else
        check("odd_adr_rd", rd, 16'h3412);
`endif

        // Random traffic over a small word pool with random aliasing bits.
        for (int n = 0; n < 80; n++) begin
            int          k, ix;
            logic        w, lsb;
            logic [1:0]  s;
            logic [4:0]  hb;
            logic [15:0] a, d;
            k   = int'($urandom_range(0, 2));
            ix  = 256 + 3 * int'($urandom_range(0, 7));
            hb  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            lsb = 1'($urandom_range(0, 1));
            w   = 1'($urandom_range(0, 1));
            s   = 2'($urandom_range(0, 3));
            d   = 16'($urandom);
            if (!known[k][ix]) begin
                w = 1'b1; s = 2'b11; hb = 5'd0; lsb = 1'b0;
            end
            a = {hb, 10'(ix), lsb};
            xfer(k, w, s, a, d, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
